// File: rtl/sr_lifo_stack_pkg.sv
// Shared definitions for the CPU-side LIFO stack: default geometry and the
// per-edge action decode.
package sr_lifo_stack_pkg;

    localparam int LIFO_DATA_W = 16;
    localparam int LIFO_DEPTH  = 16;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_PUSH,
        ACT_OVF,
        ACT_POP,
        ACT_UNF,
        ACT_REPLACE,
        ACT_UNF_PUSH
    } lifo_act_e;

endpackage

// File: rtl/sr_lifo_stack_if.sv
// Request/response bundle between the core's PUSH/POP datapath and the stack.
interface sr_lifo_stack_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_req_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              rd_req_i;
    logic              clr_err_i;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   amount_o;
    logic              empty_o;
    logic              full_o;
    logic              ovf_o;
    logic              unf_o;

    modport master (
        output wr_req_i, wr_data_i, rd_req_i, clr_err_i,
        input  rd_data, amount_o, empty_o, full_o, ovf_o, unf_o
    );

    modport slave (
        input  wr_req_i, wr_data_i, rd_req_i, clr_err_i,
        output rd_data, amount_o, empty_o, full_o, ovf_o, unf_o
    );
endinterface

// File: rtl/sr_lifo_stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sr_lifo_stack_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sr_lifo_stack.sv
// LIFO stack beside the single-cycle core: PUSH stores rs1[15:0], POP returns
// the top entry combinationally for same-cycle writeback.
module sr_lifo_stack
    import sr_lifo_stack_pkg::*;
#(
    parameter int DATA_W = LIFO_DATA_W,
    parameter int DEPTH  = LIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    sr_lifo_stack_if.slave bus
);
    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0]   sp;
    logic [ADDR_W:0]   sp_nxt;
    logic [ADDR_W-1:0] top_idx;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] mem_rd;
    logic              empty;
    logic              full;
    logic              wr_en;
    logic              set_ovf;
    logic              set_unf;
    logic              ovf;
    logic              unf;
    lifo_act_e         act;

    // Status decodes from the registered pointer only.
    assign empty   = (sp == '0);
    assign full    = (sp == FULL_CNT);
    assign top_idx = sp[ADDR_W-1:0] - 1'b1;

    always_comb begin
        act = ACT_HOLD;
        casez ({bus.wr_req_i, bus.rd_req_i, empty, full})
            4'b00??: act = ACT_HOLD;
            4'b10?0: act = ACT_PUSH;
            4'b10?1: act = ACT_OVF;
            4'b010?: act = ACT_POP;
            4'b011?: act = ACT_UNF;
            4'b110?: act = ACT_REPLACE;
            4'b111?: act = ACT_UNF_PUSH;
            default: act = ACT_HOLD;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sp[ADDR_W-1:0];
        sp_nxt  = sp;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (act)
            ACT_PUSH: begin
                wr_en  = 1'b1;
                sp_nxt = sp + 1'b1;
            end
            ACT_OVF:  set_ovf = 1'b1;
            ACT_POP:  sp_nxt  = sp - 1'b1;
            ACT_UNF:  set_unf = 1'b1;
            ACT_REPLACE: begin
                wr_en   = 1'b1;
                wr_addr = top_idx;
            end
            // Empty pop fails but the paired push still lands in slot 0.
            ACT_UNF_PUSH: begin
                wr_en   = 1'b1;
                wr_addr = '0;
                sp_nxt  = (ADDR_W+1)'(1);
                set_unf = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            sp  <= sp_nxt;
            ovf <= set_ovf | (ovf & ~bus.clr_err_i);
            unf <= set_unf | (unf & ~bus.clr_err_i);
        end
    end

    sr_lifo_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.wr_data_i),
        .rd_addr (top_idx),
        .rd_data (mem_rd)
    );

    assign bus.rd_data  = empty ? '0 : mem_rd;
    assign bus.amount_o = sp;
    assign bus.empty_o  = empty;
    assign bus.full_o   = full;
    assign bus.ovf_o    = ovf;
    assign bus.unf_o    = unf;
endmodule

// File: tb/tb_sr_lifo_stack.sv
// Bench for sr_lifo_stack: directed table, corner sequences, then random
// traffic against a queue-based stack model.
module tb_sr_lifo_stack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sr_lifo_stack_if #(.DATA_W(16), .DEPTH(16)) bus ();

    sr_lifo_stack #(.DATA_W(16), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] stk [$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    typedef struct {
        logic        w;
        logic        r;
        logic [15:0] d;
        logic        c;
        logic [15:0] rd;
        logic [4:0]  amt;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic w, input logic r, input logic [15:0] d,
                                input logic c, input logic [15:0] rd,
                                input logic [4:0] amt, input logic ovf, input logic unf);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.c = c;
        v.rd = rd; v.amt = amt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] top;
        top = (stk.size() == 0) ? 16'h0 : stk[stk.size()-1];
        check({tag, " rd_data"}, 32'(bus.rd_data), 32'(top));
        check({tag, " amount"},  32'(bus.amount_o), 32'(stk.size()));
        check({tag, " empty"},   32'(bus.empty_o), 32'(stk.size() == 0));
        check({tag, " full"},    32'(bus.full_o), 32'(stk.size() == 16));
        check({tag, " ovf"},     32'(bus.ovf_o), 32'(m_ovf));
        check({tag, " unf"},     32'(bus.unf_o), 32'(m_unf));
    endtask

    task automatic model_update(input logic w, input logic r, input logic [15:0] d, input logic c);
        logic new_ovf;
        logic new_unf;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (w && r) begin
            if (stk.size() == 0) begin
                new_unf = 1'b1;
                stk.push_back(d);
            end else begin
                stk[stk.size()-1] = d;
            end
        end else if (w) begin
            if (stk.size() == 16) new_ovf = 1'b1;
            else stk.push_back(d);
        end else if (r) begin
            if (stk.size() == 0) new_unf = 1'b1;
            else void'(stk.pop_back());
        end
        m_ovf = new_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = new_unf ? 1'b1 : (c ? 1'b0 : m_unf);
    endtask

    task automatic drive(input logic w, input logic r, input logic [15:0] d, input logic c);
        bus.wr_req_i  = w;
        bus.rd_req_i  = r;
        bus.wr_data_i = d;
        bus.clr_err_i = c;
    endtask

    task automatic step(input logic w, input logic r, input logic [15:0] d, input logic c,
                        input string tag);
        drive(w, r, d, c);
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        model_update(w, r, d, c);
        #1;
    endtask

    task automatic model_reset();
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset amount", 32'(bus.amount_o), 32'd0);
        check("reset empty",  32'(bus.empty_o), 32'd1);
        check("reset rd",     32'(bus.rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Each row: inputs, then outputs expected before that row's edge.
        tbl[0]  = mk(1, 0, 16'h1111, 0, 16'h0000, 5'd0, 0, 0);
        tbl[1]  = mk(1, 0, 16'h2222, 0, 16'h1111, 5'd1, 0, 0);
        tbl[2]  = mk(1, 0, 16'h3333, 0, 16'h2222, 5'd2, 0, 0);
        tbl[3]  = mk(0, 1, 16'h0000, 0, 16'h3333, 5'd3, 0, 0);
        tbl[4]  = mk(0, 1, 16'h0000, 0, 16'h2222, 5'd2, 0, 0);
        tbl[5]  = mk(0, 1, 16'h0000, 0, 16'h1111, 5'd1, 0, 0);
        tbl[6]  = mk(0, 1, 16'h0000, 0, 16'h0000, 5'd0, 0, 0);
        tbl[7]  = mk(0, 0, 16'h0000, 0, 16'h0000, 5'd0, 0, 1);
        tbl[8]  = mk(0, 0, 16'h0000, 1, 16'h0000, 5'd0, 0, 1);
        tbl[9]  = mk(1, 0, 16'hAAAA, 0, 16'h0000, 5'd0, 0, 0);
        tbl[10] = mk(1, 1, 16'h5555, 0, 16'hAAAA, 5'd1, 0, 0);
        tbl[11] = mk(0, 0, 16'h0000, 0, 16'h5555, 5'd1, 0, 0);
        tbl[12] = mk(0, 1, 16'h0000, 0, 16'h5555, 5'd1, 0, 0);
        tbl[13] = mk(1, 1, 16'h4444, 0, 16'h0000, 5'd0, 0, 0);
        tbl[14] = mk(0, 0, 16'h0000, 0, 16'h4444, 5'd1, 0, 1);
        tbl[15] = mk(0, 1, 16'h0000, 1, 16'h4444, 5'd1, 0, 1);
        tbl[16] = mk(0, 1, 16'h0000, 0, 16'h0000, 5'd0, 0, 0);
        tbl[17] = mk(0, 0, 16'h0000, 0, 16'h0000, 5'd0, 0, 1);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].c);
            @(negedge clk);
            check($sformatf("tbl%0d rd", i),    32'(bus.rd_data), 32'(tbl[i].rd));
            check($sformatf("tbl%0d amt", i),   32'(bus.amount_o), 32'(tbl[i].amt));
            check($sformatf("tbl%0d empty", i), 32'(bus.empty_o), 32'(tbl[i].amt == 0));
            check($sformatf("tbl%0d ovf", i),   32'(bus.ovf_o), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d unf", i),   32'(bus.unf_o), 32'(tbl[i].unf));
            @(posedge clk);
            model_update(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].c);
            #1;
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, "clr");

        // Fill to full, overflow, then push+pop while full.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'(i), 1'b0, "fill");
        check("full flag",   32'(bus.full_o), 32'd1);
        check("full amount", 32'(bus.amount_o), 32'd16);
        step(1'b1, 1'b0, 16'hBEEF, 1'b0, "ovf push");
        check("ovf set",      32'(bus.ovf_o), 32'd1);
        check("ovf top kept", 32'(bus.rd_data), 32'h000F);
        step(1'b0, 1'b0, 16'h0, 1'b1, "ovf clr");
        check("ovf cleared", 32'(bus.ovf_o), 32'd0);
        step(1'b1, 1'b1, 16'h7777, 1'b0, "full replace");
        check("replace no ovf", 32'(bus.ovf_o), 32'd0);
        check("replace amount", 32'(bus.amount_o), 32'd16);
        check("replace top",    32'(bus.rd_data), 32'h7777);
        step(1'b1, 1'b0, 16'h8888, 1'b0, "ovf again");

        // Async reset mid-cycle with a push pending.
        drive(1'b1, 1'b0, 16'h9999, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async amount", 32'(bus.amount_o), 32'd0);
        check("async empty",  32'(bus.empty_o), 32'd1);
        check("async rd",     32'(bus.rd_data), 32'd0);
        check("async ovf",    32'(bus.ovf_o), 32'd0);
        check("async unf",    32'(bus.unf_o), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        check("post reset amount", 32'(bus.amount_o), 32'd0);

        // Random traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            int pw;
            int pr;
            pw = ((i / 200) % 2 == 0) ? 70 : 30;
            pr = 100 - pw;
            step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
                 16'($urandom), 1'($urandom_range(0, 15) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
